// File: rtl/trace_pkg.sv
// Shared types for the store-trace monitor.
// MEM_TRACE_CYCLE_EN adds a cycle stamp to each record.
package trace_pkg;

  localparam int ADDR_W = 32;
  localparam int CYC_W  = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } trace_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] data;
`ifdef MEM_TRACE_CYCLE_EN
    logic [CYC_W-1:0]  cycle;
`endif
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO.
// Pointers carry one extra wrap bit so full and empty differ.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mem_trace_unit.sv
// Data-memory store tracer with cycle/instruction counters.
// Define MEM_TRACE_CYCLE_EN to stamp records and expose trace_cycle.
module mem_trace_unit
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = CYC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [ADDR_W-1:0] writedata,
  input  logic              stallD,
  input  logic              flushD,
  input  logic [ADDR_W-1:0] finish_pc,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [ADDR_W-1:0] trace_data,
`ifdef MEM_TRACE_CYCLE_EN
  output logic [CNT_W-1:0]  trace_cycle,
`endif
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count,
  output logic              done,
  output logic              overflow,
  output logic              core_hold
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] data;
`ifdef MEM_TRACE_CYCLE_EN
    logic [CNT_W-1:0]  cycle;
`endif
  } entry_t;

  trace_state_e state;
  trace_state_e state_nxt;

  entry_t wentry;
  entry_t head;
  logic   full;
  logic   empty;
  logic   at_finish;
  logic   active;
  logic   store;
  logic   pop;
  logic   push;
  logic   drop;

  assign at_finish = (pc == finish_pc);
  assign active    = (state == RUN) && !at_finish;
  assign store     = active && memwrite;
  assign pop       = !empty && trace_ready;
  // a full FIFO still takes a store when its head leaves on the same edge
  assign push      = store && (!full || pop);
  assign drop      = store && full && !pop;

  always_comb begin
    wentry      = '0;
    wentry.addr = aluout;
    wentry.data = writedata;
`ifdef MEM_TRACE_CYCLE_EN
    wentry.cycle = cycle_count + 1'b1;
`endif
  end

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      cycle_count <= '0;
      instr_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (active) begin
        cycle_count <= cycle_count + 1'b1;
        if (!stallD && !flushD) instr_count <= instr_count + 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (at_finish) state_nxt = DRAIN;
      DRAIN:   if (empty)     state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = RUN;
    endcase
  end

  assign trace_valid = !empty;
  assign trace_addr  = empty ? '0 : head.addr;
  assign trace_data  = empty ? '0 : head.data;
`ifdef MEM_TRACE_CYCLE_EN
  assign trace_cycle = empty ? '0 : head.cycle;
`endif
  assign done        = (state == DONE);
  assign core_hold   = (state != RUN) || at_finish;

endmodule

// File: tb/tb_mem_trace_unit.sv
// Directed bench for mem_trace_unit (DEPTH=4).
// Stamp checks are active when MEM_TRACE_CYCLE_EN is defined.
module tb_mem_trace_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic        stallD;
  logic        flushD;
  logic [31:0] finish_pc;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
`ifdef MEM_TRACE_CYCLE_EN
  logic [31:0] trace_cycle;
`endif
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
  logic        done;
  logic        overflow;
  logic        core_hold;

  int n_cmp;
  int n_err;

  mem_trace_unit #(
    .DEPTH (4),
    .CNT_W (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .memwrite    (memwrite),
    .aluout      (aluout),
    .writedata   (writedata),
    .stallD      (stallD),
    .flushD      (flushD),
    .finish_pc   (finish_pc),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
`ifdef MEM_TRACE_CYCLE_EN
    .trace_cycle (trace_cycle),
`endif
    .cycle_count (cycle_count),
    .instr_count (instr_count),
    .done        (done),
    .overflow    (overflow),
    .core_hold   (core_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset       = 1'b0;
    pc          = 32'h0;
    memwrite    = 1'b0;
    aluout      = 32'h0;
    writedata   = 32'h0;
    stallD      = 1'b0;
    flushD      = 1'b0;
    trace_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    pc          = 32'h0;
    memwrite    = 1'b1;
    aluout      = 32'hDEAD;
    writedata   = 32'hBEEF;
    stallD      = 1'b0;
    flushD      = 1'b0;
    trace_ready = 1'b0;
    step();
    step();
    n_cmp++;
    if (trace_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid: got %b want 0", trace_valid);
    end
    n_cmp++;
    if (done !== 1'b0 || overflow !== 1'b0 || core_hold !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flags: got %b%b%b want 000",
               done, overflow, core_hold);
    end
    n_cmp++;
    if (cycle_count !== 32'h0 || instr_count !== 32'h0) begin
      n_err++;
      $display("FAIL rst_cnt: got %h/%h want 0/0",
               cycle_count, instr_count);
    end
    n_cmp++;
    if (trace_addr !== 32'h0 || trace_data !== 32'h0) begin
      n_err++;
      $display("FAIL rst_rec: got %h/%h want 0/0", trace_addr, trace_data);
    end
`ifdef MEM_TRACE_CYCLE_EN
    n_cmp++;
    if (trace_cycle !== 32'h0) begin
      n_err++;
      $display("FAIL rst_cyc: got %h want 0", trace_cycle);
    end
`endif
    memwrite = 1'b0;
  endtask

  task automatic test_three_stores;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] ed;
    do_reset();
    trace_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      ev = (c == 3) || (c == 5) || (c == 6);
      ea = (c == 3) ? 32'h54 : (c == 5) ? 32'h58 : 32'h5C;
      ed = (c == 3) ? 32'h7  : (c == 5) ? 32'hA  : 32'h11;
      memwrite  = ev;
      aluout    = ea;
      writedata = ed;
      step();
      n_cmp++;
      if (trace_valid !== ev) begin
        n_err++;
        $display("FAIL ts_valid c%0d: got %b want %b", c, trace_valid, ev);
      end
      if (ev) begin
        n_cmp++;
        if (trace_addr !== ea || trace_data !== ed) begin
          n_err++;
          $display("FAIL ts_rec c%0d: got %h/%h want %h/%h",
                   c, trace_addr, trace_data, ea, ed);
        end
`ifdef MEM_TRACE_CYCLE_EN
        n_cmp++;
        if (trace_cycle !== 32'(c)) begin
          n_err++;
          $display("FAIL ts_stamp c%0d: got %0d want %0d", c, trace_cycle, c);
        end
`endif
      end
    end
    memwrite = 1'b0;
    n_cmp++;
    if (cycle_count !== 32'd7 || instr_count !== 32'd7) begin
      n_err++;
      $display("FAIL ts_cnt: got %0d/%0d want 7/7", cycle_count, instr_count);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ts_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      memwrite  = 1'b1;
      aluout    = 32'h100 + 32'(4 * i);
      writedata = 32'(i + 1);
      step();
      n_cmp++;
      if (overflow !== (i >= 4)) begin
        n_err++;
        $display("FAIL ov_flag s%0d: got %b want %b", i, overflow, i >= 4);
      end
      n_cmp++;
      if (trace_valid !== 1'b1 || trace_addr !== 32'h100) begin
        n_err++;
        $display("FAIL ov_head s%0d: got %b/%h want 1/100",
                 i, trace_valid, trace_addr);
      end
    end
    memwrite    = 1'b0;
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (trace_addr !== 32'h100 + 32'(4 * i) || trace_data !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL ov_drain r%0d: got %h/%h want %h/%h", i,
                 trace_addr, trace_data, 32'h100 + 32'(4 * i), i + 1);
      end
`ifdef MEM_TRACE_CYCLE_EN
      n_cmp++;
      if (trace_cycle !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL ov_stamp r%0d: got %0d want %0d", i, trace_cycle, i + 1);
      end
`endif
      step();
    end
    n_cmp++;
    if (trace_valid !== 1'b0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ov_end: got %b/%b want 0/1", trace_valid, overflow);
    end
  endtask

  task automatic test_full_push_pop;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      memwrite  = 1'b1;
      aluout    = 32'h200 + 32'(4 * i);
      writedata = 32'h20 + 32'(i);
      step();
    end
    memwrite    = 1'b1;
    aluout      = 32'h210;
    writedata   = 32'h24;
    trace_ready = 1'b1;
    step();
    memwrite    = 1'b0;
    trace_ready = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL fp_ovf: got %b want 0", overflow);
    end
    trace_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (trace_valid !== 1'b1 ||
          trace_addr !== 32'h200 + 32'(4 * i) ||
          trace_data !== 32'h20 + 32'(i)) begin
        n_err++;
        $display("FAIL fp_rec r%0d: got %b/%h/%h want 1/%h/%h", i,
                 trace_valid, trace_addr, trace_data,
                 32'h200 + 32'(4 * i), 32'h20 + 32'(i));
      end
`ifdef MEM_TRACE_CYCLE_EN
      n_cmp++;
      if (trace_cycle !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL fp_stamp r%0d: got %0d want %0d", i, trace_cycle, i + 1);
      end
`endif
      step();
    end
    n_cmp++;
    if (trace_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fp_empty: got %b want 0", trace_valid);
    end
  endtask

  task automatic test_finish;
    do_reset();
    memwrite = 1'b1;
    aluout   = 32'h300;
    writedata = 32'h1;
    step();
    aluout    = 32'h304;
    writedata = 32'h2;
    step();
    n_cmp++;
    if (core_hold !== 1'b0) begin
      n_err++;
      $display("FAIL fin_hold0: got %b want 0", core_hold);
    end
    aluout    = 32'h308;
    writedata = 32'h3;
    pc        = 32'h3C;
    #1;
    n_cmp++;
    if (core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL fin_hold_comb: got %b want 1", core_hold);
    end
    step();
    n_cmp++;
    if (cycle_count !== 32'd2 || instr_count !== 32'd2) begin
      n_err++;
      $display("FAIL fin_frozen: got %0d/%0d want 2/2",
               cycle_count, instr_count);
    end
    pc = 32'h40;
    step();
    n_cmp++;
    if (core_hold !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL fin_drain: got hold %b done %b want 1/0", core_hold, done);
    end
    n_cmp++;
    if (trace_valid !== 1'b1 || trace_addr !== 32'h300) begin
      n_err++;
      $display("FAIL fin_head0: got %b/%h want 1/300", trace_valid, trace_addr);
    end
    memwrite    = 1'b0;
    trace_ready = 1'b1;
    step();
    n_cmp++;
    if (trace_addr !== 32'h304 || done !== 1'b0) begin
      n_err++;
      $display("FAIL fin_head1: got %h/%b want 304/0", trace_addr, done);
    end
    step();
    n_cmp++;
    if (trace_valid !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL fin_empty: got %b/%b want 0/0", trace_valid, done);
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || trace_valid !== 1'b0 || cycle_count !== 32'd2) begin
      n_err++;
      $display("FAIL fin_done: got %b/%b/%0d want 1/0/2",
               done, trace_valid, cycle_count);
    end
  endtask

  task automatic test_counters;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      stallD = (c == 2) || (c == 5);
      flushD = (c == 8);
      step();
    end
    stallD = 1'b0;
    flushD = 1'b0;
    n_cmp++;
    if (cycle_count !== 32'd10) begin
      n_err++;
      $display("FAIL cnt_cycle: got %0d want 10", cycle_count);
    end
    n_cmp++;
    if (instr_count !== 32'd7) begin
      n_err++;
      $display("FAIL cnt_instr: got %0d want 7", instr_count);
    end
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      memwrite  = 1'b1;
      aluout    = 32'h400 + 32'(4 * i);
      writedata = 32'(i);
      step();
    end
    memwrite = 1'b0;
    pc       = 32'h3C;
    step();
    pc = 32'h0;
    step();
    n_cmp++;
    if (core_hold !== 1'b1 || trace_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rm_pre: got %b/%b want 1/1", core_hold, trace_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (trace_valid !== 1'b0 || done !== 1'b0 ||
        overflow !== 1'b0 || core_hold !== 1'b0) begin
      n_err++;
      $display("FAIL rm_flags: got %b%b%b%b want 0000",
               trace_valid, done, overflow, core_hold);
    end
    n_cmp++;
    if (cycle_count !== 32'h0 || instr_count !== 32'h0 ||
        trace_addr !== 32'h0 || trace_data !== 32'h0) begin
      n_err++;
      $display("FAIL rm_vals: got %h/%h/%h/%h want 0",
               cycle_count, instr_count, trace_addr, trace_data);
    end
    step();
    reset = 1'b1;
    step();
    memwrite  = 1'b1;
    aluout    = 32'h500;
    writedata = 32'h9;
    step();
    memwrite = 1'b0;
    n_cmp++;
    if (trace_valid !== 1'b1 || trace_addr !== 32'h500 ||
        cycle_count !== 32'd2) begin
      n_err++;
      $display("FAIL rm_restart: got %b/%h/%0d want 1/500/2",
               trace_valid, trace_addr, cycle_count);
    end
`ifdef MEM_TRACE_CYCLE_EN
    n_cmp++;
    if (trace_cycle !== 32'd2) begin
      n_err++;
      $display("FAIL rm_stamp: got %0d want 2", trace_cycle);
    end
`endif
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    finish_pc = 32'h3C;
    test_reset();
    test_three_stores();
    test_overflow();
    test_full_push_pop();
    test_finish();
    test_counters();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
